lvds_tx_framer: RTL and testbench

Framing and serialisation stage directly upstream of the LVDS output serializer wrapper. Accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and drives `dev_data` (wired to the wrapper's `data_out_from_device`) one DEV_W-bit slice per clock, MSB slice first. After reset or on request it emits a training sequence and a sync word before payload. When no payload is available it fills with idle words.

---
 rtl/lvds_tx_pkg.sv | 16 +
 rtl/lvds_tx_fifo.sv | 53 +++++
 rtl/lvds_tx_framer.sv | 140 ++++++++++++++
 tb/tb_lvds_tx_framer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_tx_pkg.sv
// Shared types and default framing words for the LVDS transmit framer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lvds_tx_pkg;

    typedef enum logic [1:0] {
        TRAIN = 2'd0,
        SYNC  = 2'd1,
        DATA  = 2'd2
    } tx_state_t;

    localparam logic [7:0] DEF_TRAIN_WORD = 8'hAA;
    localparam logic [7:0] DEF_SYNC_WORD  = 8'h5C;
    localparam logic [7:0] DEF_IDLE_WORD  = 8'hBC;

endpackage

// File: rtl/lvds_tx_fifo.sv
// Synchronous word FIFO feeding the framer; power-of-two depth, no bypass.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: full blocks pushes, empty blocks pops; both decoded from registered pointers.
module lvds_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_dat,
    input  logic              pop,
    output logic [WORD_W-1:0] head_dat,
    output logic              full,
    output logic              empty
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic              do_push;
    logic              do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/lvds_tx_framer.sv
// Frames payload words (training, sync, data/idle) and serialises them MSB slice first.
// Latency: push to top slice on dev_data is 1..N cycles; one word per N cycles.
// Backpressure: in_ready = FIFO not full, registered, no path from in_valid.
module lvds_tx_framer
    import lvds_tx_pkg::*;
#(
    parameter int                DEV_W      = 1,
    parameter int                WORD_W     = 8,
    parameter int                FIFO_DEPTH = 4,
    parameter int                TRAIN_LEN  = 16,
    parameter logic [WORD_W-1:0] TRAIN_WORD = WORD_W'(DEF_TRAIN_WORD),
    parameter logic [WORD_W-1:0] SYNC_WORD  = WORD_W'(DEF_SYNC_WORD),
    parameter logic [WORD_W-1:0] IDLE_WORD  = WORD_W'(DEF_IDLE_WORD)
) (
    input  logic              clk,
    input  logic              io_reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              train_req,
    output logic [DEV_W-1:0]  dev_data,
    output logic              link_up,
    output logic [15:0]       idle_cnt
);

    localparam int             N           = WORD_W / DEV_W;
    localparam int             SCW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [SCW-1:0] SLICE_LAST  = SCW'(N - 1);
    localparam logic [7:0]     TRAIN_LEN_C = 8'(TRAIN_LEN);

    tx_state_t         state;
    tx_state_t         nxt_state;
    logic [SCW-1:0]    slice_cnt;
    logic [7:0]        train_cnt;
    logic [7:0]        nxt_train_cnt;
    logic              train_pend;
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] nxt_word;
    logic              boundary;
    logic              idle_inc;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_head;

    assign boundary  = (slice_cnt == '0);
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    lvds_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WORD_W     (WORD_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (io_reset_n),
        .push     (fifo_push),
        .push_dat (in_data),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Word selection for the next boundary; only meaningful when boundary is high.
    always_comb begin
        nxt_state     = state;
        nxt_word      = IDLE_WORD;
        nxt_train_cnt = train_cnt;
        fifo_pop      = 1'b0;
        idle_inc      = 1'b0;
        if (boundary) begin
            if (train_pend) begin
                // The retrain boundary itself sends the first training word.
                nxt_state     = TRAIN;
                nxt_word      = TRAIN_WORD;
                nxt_train_cnt = 8'd1;
            end else begin
                case (state)
                    TRAIN: begin
                        if (train_cnt == TRAIN_LEN_C) begin
                            nxt_state = SYNC;
                            nxt_word  = SYNC_WORD;
                        end else begin
                            nxt_word      = TRAIN_WORD;
                            nxt_train_cnt = train_cnt + 8'd1;
                        end
                    end
                    SYNC, DATA: begin
                        nxt_state = DATA;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            nxt_word = fifo_head;
                        end else begin
                            nxt_word = IDLE_WORD;
                            idle_inc = 1'b1;
                        end
                    end
                    default: begin
                        nxt_state     = TRAIN;
                        nxt_word      = TRAIN_WORD;
                        nxt_train_cnt = 8'd1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge io_reset_n) begin
        if (!io_reset_n) begin
            state      <= TRAIN;
            slice_cnt  <= '0;
            train_cnt  <= 8'd0;
            train_pend <= 1'b0;
            shift_reg  <= '0;
            dev_data   <= '0;
            link_up    <= 1'b0;
            idle_cnt   <= 16'd0;
        end else begin
            slice_cnt <= (slice_cnt == SLICE_LAST) ? '0 : slice_cnt + 1'b1;
            // A request arriving on a boundary is held for the following one.
            train_pend <= boundary ? train_req : (train_pend | train_req);
            if (boundary) begin
                state     <= nxt_state;
                train_cnt <= nxt_train_cnt;
                dev_data  <= nxt_word[WORD_W-1 -: DEV_W];
                shift_reg <= nxt_word << DEV_W;
                link_up   <= (nxt_state == DATA);
                if (idle_inc && (idle_cnt != 16'hFFFF)) begin
                    idle_cnt <= idle_cnt + 16'd1;
                end
            end else begin
                dev_data  <= shift_reg[WORD_W-1 -: DEV_W];
                shift_reg <= shift_reg << DEV_W;
            end
        end
    end

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Bench for lvds_tx_framer: bit-serial instance (TRAIN_LEN=2) plus a 4-bit slice instance.
// Latency: n/a. Backpressure: exercised through in_valid held against a full FIFO.
// Output words are reassembled from dev_data and matched against a queue of expected words.
module tb_lvds_tx_framer;

    localparam logic [7:0] TRW = 8'hAA;
    localparam logic [7:0] SYW = 8'h5C;
    localparam logic [7:0] IDW = 8'hBC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        train_req;
    logic        in_ready;
    logic [0:0]  dev_data;
    logic        link_up;
    logic [15:0] idle_cnt;

    logic        w_valid;
    logic [7:0]  w_data;
    logic        w_train_req;
    logic        w_ready;
    logic [3:0]  w_dev;
    logic        w_link;
    logic [15:0] w_idle;

    typedef struct { logic [7:0] w; logic lk; logic lk_or; logic [15:0] ic; } cap_t;
    typedef struct { logic [7:0] w; logic lk; } exp_t;

    cap_t        cap_q[$];
    exp_t        exp_q[$];
    logic [7:0]  wq[$];
    int          checks = 0;
    int          failures = 0;
    int          ecnt;

    always #5 clk = ~clk;

    lvds_tx_framer #(.DEV_W(1), .WORD_W(8), .FIFO_DEPTH(4), .TRAIN_LEN(2)) dut (
        .clk(clk), .io_reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .train_req(train_req), .dev_data(dev_data),
        .link_up(link_up), .idle_cnt(idle_cnt)
    );

    lvds_tx_framer #(.DEV_W(4), .WORD_W(8), .FIFO_DEPTH(4), .TRAIN_LEN(2)) dut_wide (
        .clk(clk), .io_reset_n(rst_n), .in_valid(w_valid), .in_ready(w_ready),
        .in_data(w_data), .train_req(w_train_req), .dev_data(w_dev),
        .link_up(w_link), .idle_cnt(w_idle)
    );

    // Edge count since reset release; word boundaries fall on edges where ecnt % 8 == 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    int          nb;
    logic [7:0]  acc;
    logic        cur_lk, cur_or;
    logic [15:0] cur_ic;
    always @(negedge clk) begin
        if (ecnt == 0) begin
            nb = 0;
        end else begin
            if (nb == 0) begin
                cur_lk = link_up; cur_ic = idle_cnt; cur_or = 1'b0;
            end
            acc = {acc[6:0], dev_data};
            cur_or = cur_or | link_up;
            nb++;
            if (nb == 8) begin
                cap_q.push_back('{w: acc, lk: cur_lk, lk_or: cur_or, ic: cur_ic});
                nb = 0;
            end
        end
    end

    task automatic get_word(output cap_t c, output bit ok);
        int t = 0;
        ok = 1'b0;
        while (cap_q.size() == 0 && t < 40) begin @(posedge clk); t++; end
        if (cap_q.size() != 0) begin c = cap_q.pop_front(); ok = 1'b1; end
    endtask

    task automatic get_nonidle(output cap_t c, output bit ok, output int nidle, output logic [15:0] last_ic);
        nidle = 0; last_ic = 16'd0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            get_word(c, ok);
            if (!ok || c.w != IDW) return;
            nidle++; last_ic = c.ic;
        end
        ok = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d);
        int t = 0;
        @(negedge clk); in_valid = 1'b1; in_data = d;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        @(posedge clk); #1; in_valid = 1'b0;
        exp_q.push_back('{w: d, lk: 1'b1});
    endtask

    task automatic align_after_boundary();
        @(negedge clk);
        while (ecnt % 8 != 1) @(negedge clk);
    endtask

    task automatic test_reset();
        cap_t c; exp_t e; bit ok;
        rst_n = 1'b1; in_valid = 1'b0; in_data = 8'h00; train_req = 1'b0;
        w_valid = 1'b0; w_data = 8'h00; w_train_req = 1'b0;
        #1 rst_n = 1'b0;
        #12;
        checks++; if (dev_data !== 1'b0) begin failures++; $display("FAIL rst_dev_data got=%b exp=0", dev_data); end
        checks++; if (link_up !== 1'b0) begin failures++; $display("FAIL rst_link_up got=%b exp=0", link_up); end
        checks++; if (idle_cnt !== 16'd0) begin failures++; $display("FAIL rst_idle_cnt got=%0d exp=0", idle_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        exp_q.push_back('{w: TRW, lk: 1'b0});
        exp_q.push_back('{w: TRW, lk: 1'b0});
        exp_q.push_back('{w: SYW, lk: 1'b0});
        exp_q.push_back('{w: IDW, lk: 1'b1});
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            get_word(c, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL train_word%0d got=timeout exp=%h", i, e.w); end
            else begin
                if (c.w !== e.w) begin failures++; $display("FAIL train_word%0d got=%h exp=%h", i, c.w, e.w); end
                checks++;
                if (c.lk !== e.lk || c.lk_or !== e.lk) begin
                    failures++; $display("FAIL train_link%0d got=%b/%b exp=%b", i, c.lk, c.lk_or, e.lk);
                end
            end
        end
        checks++; if (c.ic !== 16'd1) begin failures++; $display("FAIL first_idle_cnt got=%0d exp=1", c.ic); end
    endtask

    task automatic test_payload();
        cap_t c; exp_t e; bit ok; int n; logic [15:0] prev_ic;
        @(posedge clk); cap_q.delete();
        push_word(8'h3C);
        push_word(8'hC3);
        get_nonidle(c, ok, n, prev_ic);
        e = exp_q.pop_front();
        checks++;
        if (!ok || n == 0) begin failures++; $display("FAIL payload_first got=none exp=%h", e.w); end
        else begin
            if (c.w !== e.w || c.lk !== 1'b1) begin failures++; $display("FAIL payload_first got=%h/%b exp=%h/1", c.w, c.lk, e.w); end
            checks++; if (c.ic !== prev_ic) begin failures++; $display("FAIL payload_idle0 got=%0d exp=%0d", c.ic, prev_ic); end
        end
        e = exp_q.pop_front();
        get_word(c, ok);
        checks++; if (!ok || c.w !== e.w) begin failures++; $display("FAIL payload_second got=%h exp=%h", c.w, e.w); end
        checks++; if (c.ic !== prev_ic) begin failures++; $display("FAIL payload_idle1 got=%0d exp=%0d", c.ic, prev_ic); end
        get_word(c, ok);
        checks++; if (!ok || c.w !== IDW || c.ic !== prev_ic + 16'd1) begin
            failures++; $display("FAIL payload_after got=%h/%0d exp=%h/%0d", c.w, c.ic, IDW, prev_ic + 16'd1);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] bp [6];
        cap_t c; exp_t e; bit ok, acc_ok; int n, k, t; logic [15:0] ic;
        bp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        @(posedge clk); cap_q.delete();
        align_after_boundary();
        k = 0; t = 0;
        in_valid = 1'b1; in_data = bp[0];
        while (k < 6 && t < 300) begin
            acc_ok = in_ready;
            @(posedge clk); #1;
            if (acc_ok) begin
                exp_q.push_back('{w: bp[k], lk: 1'b1});
                k++;
                if (k == 4) begin
                    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
                end
                if (k < 6) in_data = bp[k];
                else in_valid = 1'b0;
            end
            @(negedge clk); t++;
        end
        in_valid = 1'b0;
        checks++; if (k != 6) begin failures++; $display("FAIL bp_accepted got=%0d exp=6", k); end
        get_nonidle(c, ok, n, ic);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) get_word(c, ok);
            e = exp_q.pop_front();
            checks++; if (!ok || c.w !== e.w) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, c.w, e.w); end
        end
        for (int i = 0; i < 2; i++) begin
            get_word(c, ok);
            checks++; if (!ok || c.w !== IDW) begin failures++; $display("FAIL bp_tail%0d got=%h exp=%h", i, c.w, IDW); end
        end
    endtask

    task automatic test_retrain();
        cap_t c; exp_t e; bit ok; int n; logic [15:0] ic;
        @(posedge clk); cap_q.delete();
        align_after_boundary();
        in_valid = 1'b1; in_data = 8'h12;
        @(posedge clk); #1 in_data = 8'h34;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 train_req = 1'b1;
        @(posedge clk); #1 train_req = 1'b0;
        exp_q.push_back('{w: TRW, lk: 1'b0});
        exp_q.push_back('{w: TRW, lk: 1'b0});
        exp_q.push_back('{w: SYW, lk: 1'b0});
        exp_q.push_back('{w: 8'h12, lk: 1'b1});
        exp_q.push_back('{w: 8'h34, lk: 1'b1});
        get_nonidle(c, ok, n, ic);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) get_word(c, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || c.w !== e.w || c.lk !== e.lk || c.lk_or !== e.lk) begin
                failures++; $display("FAIL retrain_word%0d got=%h/%b/%b exp=%h/%b", i, c.w, c.lk, c.lk_or, e.w, e.lk);
            end
        end
    endtask

    task automatic test_wide();
        logic [7:0] e; bit found;
        @(negedge clk);
        checks++; if (w_ready !== 1'b1 || w_link !== 1'b1) begin failures++; $display("FAIL wide_ready_link got=%b/%b exp=1/1", w_ready, w_link); end
        w_valid = 1'b1; w_data = 8'hA5; wq.push_back(8'hA5);
        @(posedge clk); #1 w_valid = 1'b0;
        e = wq.pop_front();
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (w_dev === e[7:4]) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL wide_hi got=%h exp=%h", w_dev, e[7:4]); end
        @(negedge clk);
        checks++; if (w_dev !== e[3:0]) begin failures++; $display("FAIL wide_lo got=%h exp=%h", w_dev, e[3:0]); end
    endtask

    task automatic test_async_reset();
        logic [7:0] v [4];
        cap_t c; exp_t e; bit ok; int t;
        v = '{8'h71, 8'h72, 8'h73, 8'h74};
        align_after_boundary();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = v[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ar_full got=%b exp=0", in_ready); end
        t = 0;
        @(negedge clk);
        while (!(dev_data === 1'b1 && link_up === 1'b1) && t < 40) begin @(negedge clk); t++; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dev_data !== 1'b0) begin failures++; $display("FAIL ar_dev_data got=%b exp=0", dev_data); end
        checks++; if (link_up !== 1'b0) begin failures++; $display("FAIL ar_link_up got=%b exp=0", link_up); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready got=%b exp=1", in_ready); end
        checks++; if (idle_cnt !== 16'd0) begin failures++; $display("FAIL ar_idle_cnt got=%0d exp=0", idle_cnt); end
        cap_q.delete(); exp_q.delete();
        exp_q.push_back('{w: TRW, lk: 1'b0});
        exp_q.push_back('{w: TRW, lk: 1'b0});
        exp_q.push_back('{w: SYW, lk: 1'b0});
        exp_q.push_back('{w: IDW, lk: 1'b1});
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            get_word(c, ok);
            checks++;
            if (!ok || c.w !== e.w || c.lk !== e.lk) begin
                failures++; $display("FAIL ar_word%0d got=%h/%b exp=%h/%b", i, c.w, c.lk, e.w, e.lk);
            end
        end
        checks++; if (c.ic !== 16'd1) begin failures++; $display("FAIL ar_fifo_empty got=%0d exp=1", c.ic); end
    endtask

    initial begin
        test_reset();
        test_payload();
        test_backpressure();
        test_retrain();
        test_wide();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
